// File: rtl/mul_div_unit_pkg.sv
// Shared HI/LO unit definitions: op encodings, funct decode and FSM state type.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic is_muldiv_funct(logic [5:0] funct);
    return funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

  // MULT..DIVU funct codes are contiguous, so the low two bits are the op.
  function automatic op_t funct_to_op(logic [5:0] funct);
    return op_t'(funct[1:0]);
  endfunction

  function automatic logic op_is_div(op_t o);
    return o inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic op_is_signed(op_t o);
    return o inside {MD_MULT, MD_DIV};
  endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of the magnitude datapath: right-shifting shift-add multiply
// or left-shifting restoring divide.
module mul_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] shifter,
  input  logic [WIDTH-1:0] operand,
  input  logic             isDiv,
  output logic [WIDTH:0]   nextAcc,
  output logic [WIDTH-1:0] nextShifter
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = shifter[0] ? (acc + {1'b0, operand}) : acc;
    shifted = {acc[WIDTH-1:0], shifter[WIDTH-1]};
    // remainder < divisor keeps shifted-operand within +/-2^WIDTH, so bit WIDTH is the borrow
    diff    = shifted - {1'b0, operand};
    if (isDiv) begin
      nextAcc     = diff[WIDTH] ? shifted : diff;
      nextShifter = {shifter[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      nextAcc     = {1'b0, sum[WIDTH:1]};
      nextShifter = {sum[0], shifter[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide engine; owns HI/LO and handles MTHI/MTLO.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             wrHi,
  input  logic             wrLo,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mul_div_unit_pkg::*;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t state, nextState;
  op_t       opReg;
  logic      signA, signB;
  logic [WIDTH-1:0]   aRaw, operand, shifter, nextShifter;
  logic [WIDTH:0]     acc, nextAcc;
  logic [CW-1:0]      count;
  logic               lastStep, startSigned, sA, sB, negRes, isDiv;
  logic [WIDTH-1:0]   magA, magB, quot, rem, hiRes, loRes;
  logic [2*WIDTH-1:0] product;

  assign isDiv       = op_is_div(opReg);
  assign lastStep    = (count == CW'(WIDTH - 1));
  assign startSigned = op_is_signed(op_t'(op));
  assign sA          = startSigned & opA[WIDTH-1];
  assign sB          = startSigned & opB[WIDTH-1];
  assign magA        = sA ? -opA : opA;
  assign magB        = sB ? -opB : opB;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc),
    .shifter     (shifter),
    .operand     (operand),
    .isDiv       (isDiv),
    .nextAcc     (nextAcc),
    .nextShifter (nextShifter)
  );

  always_ff @(posedge clk) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE: if (start)    nextState = ST_RUN;
      ST_RUN:  if (lastStep) nextState = ST_FIX;
      ST_FIX:                nextState = ST_IDLE;
      default:               nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Sign correction applied to the magnitude result in FIX
  always_comb begin
    negRes  = signA ^ signB;
    product = {acc[WIDTH-1:0], shifter};
    quot    = shifter;
    rem     = acc[WIDTH-1:0];
    hiRes   = '0;
    loRes   = '0;
    if (!isDiv) begin
      if (negRes) product = -product;
      hiRes = product[2*WIDTH-1:WIDTH];
      loRes = product[WIDTH-1:0];
    end else if (operand == '0) begin
      hiRes = aRaw;
      loRes = '1;
    end else begin
      hiRes = signA  ? -rem  : rem;
      loRes = negRes ? -quot : quot;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      opReg     <= MD_MULT;
      signA     <= 1'b0;
      signB     <= 1'b0;
      aRaw      <= '0;
      operand   <= '0;
      shifter   <= '0;
      acc       <= '0;
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (wrHi) hi <= wrData;
          if (wrLo) lo <= wrData;
          if (start) begin
            opReg   <= op_t'(op);
            signA   <= sA;
            signB   <= sB;
            aRaw    <= opA;
            shifter <= magA;
            operand <= magB;
            acc     <= '0;
            count   <= '0;
          end
        end
        ST_RUN: begin
          acc     <= nextAcc;
          shifter <= nextShifter;
          count   <= count + CW'(1);
        end
        ST_FIX: begin
          hi        <= hiRes;
          lo        <= loRes;
          done      <= 1'b1;
          divByZero <= isDiv && (operand == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         resetN, start, wrHi, wrLo;
  logic [1:0]   op;
  logic [W-1:0] opA, opB, wrData;
  logic         busy, done, divByZero;
  logic [W-1:0] hi, lo;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .op        (op),
    .opA       (opA),
    .opB       (opB),
    .wrHi      (wrHi),
    .wrLo      (wrLo),
    .wrData    (wrData),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics via 64-bit integer arithmetic
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint      sa, sb, p;
    logic [63:0] up;
    edz = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; {eh, el} = p; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; {eh, el} = up; end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (o == 2'd2) begin
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int disturbAt, input logic wrTogether,
                        output logic [31:0] gotHi, output logic [31:0] gotLo);
    logic [31:0] eh, el, holdHi, holdLo;
    logic        edz;
    int          n, badBusy, badHold;
    model(o, a, b, eh, el, edz);
    op = o; opA = a; opB = b; start = 1'b1;
    if (wrTogether) begin wrHi = 1'b1; wrData = 32'hCAFE_0000; end
    @(posedge clk); #1;
    start = 1'b0; wrHi = 1'b0;
    opA = $urandom; opB = $urandom;
    if (wrTogether) check("wr_with_start", hi, 32'hCAFE_0000);
    holdHi = hi; holdLo = lo;
    n = 1; badBusy = 0; badHold = 0;
    while (!done && n < 100) begin
      if (!busy) badBusy++;
      if (hi !== holdHi || lo !== holdLo) badHold++;
      if (n == disturbAt) begin
        start = 1'b1; op = 2'd0; opA = 32'd4; opB = 32'd4;
        wrHi = 1'b1; wrData = 32'hDEAD;
      end
      @(posedge clk); #1;
      n++;
      if (n == disturbAt + 1) begin start = 1'b0; wrHi = 1'b0; end
    end
    check("latency", n, 34);
    check("busy_during", badBusy, 0);
    check("hilo_hold", badHold, 0);
    check("busy_at_done", busy, 0);
    check("done", done, 1);
    check("hi", hi, eh);
    check("lo", lo, el);
    check("div_by_zero", divByZero, edz);
    gotHi = hi; gotLo = lo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] gh, gl;
    logic        sawDone;
    resetN = 1'b0; start = 1'b0; wrHi = 1'b0; wrLo = 1'b0;
    op = 2'd0; opA = '0; opB = '0; wrData = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", divByZero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    resetN = 1'b1;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, gh, gl);
    check("multu_max_hi", gh, 32'hFFFF_FFFE);
    check("multu_max_lo", gl, 32'h0000_0001);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, gh, gl);
    check("mult_neg_hi", gh, 32'hFFFF_FFFF);
    check("mult_neg_lo", gl, 32'hFFFF_FFEB);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, gh, gl);
    check("mult_min_hi", gh, 32'h4000_0000);
    check("mult_min_lo", gl, 32'h0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, gh, gl);
    check("div_negdvd_hi", gh, 32'hFFFF_FFFF);
    check("div_negdvd_lo", gl, 32'hFFFF_FFFD);
    run_op(2'd3, 32'd100, 32'd7, 0, 1'b0, gh, gl);
    check("divu_hi", gh, 32'd2);
    check("divu_lo", gl, 32'd14);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, gh, gl);
    check("div_negdvs_hi", gh, 32'd1);
    check("div_negdvs_lo", gl, 32'hFFFF_FFFD);
    run_op(2'd2, 32'd5, 32'd0, 0, 1'b0, gh, gl);
    check("div0_hi", gh, 32'd5);
    check("div0_lo", gl, 32'hFFFF_FFFF);
    run_op(2'd3, 32'h8000_0001, 32'd0, 0, 1'b0, gh, gl);
    check("divu0_hi", gh, 32'h8000_0001);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, gh, gl);
    check("div_ovf_hi", gh, 32'h0);
    check("div_ovf_lo", gl, 32'h8000_0000);
    run_op(2'd0, 32'd2, 32'd3, 5, 1'b0, gh, gl);
    check("ignored_hi", gh, 32'h0);
    check("ignored_lo", gl, 32'd6);

    wrLo = 1'b1; wrData = 32'h1234;
    @(posedge clk); #1;
    wrLo = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi_kept", hi, 32'h0);
    check("done_pulse_end", done, 0);
    wrHi = 1'b1; wrData = 32'h5678;
    @(posedge clk); #1;
    wrHi = 1'b0;
    check("mthi_hi", hi, 32'h5678);

    run_op(2'd1, 32'd6, 32'd7, 0, 1'b1, gh, gl);

    wrLo = 1'b1; wrData = 32'hAAAA_5555;
    @(posedge clk); #1;
    wrLo = 1'b0;
    op = 2'd3; opA = $urandom; opB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    resetN = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    check("abort_no_done", sawDone, 0);
    run_op(2'd3, 32'd9, 32'd3, 0, 1'b0, gh, gl);
    check("restart_hi", gh, 32'd0);
    check("restart_lo", gl, 32'd3);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 1'b0, gh, gl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
